// File: rtl/yolo_params_pkg.sv
// Shared sizes for the YOLO convolution layer plus the conv_ctrl sequencer types.
// Used by conv_ctrl, conv_out_drain, conv_ctrl_if and the convolution datapath.
package yolo_params_pkg;

  localparam int unsigned IP_DATA_WIDTH = 8;
  localparam int unsigned IFMAP_SIZE    = 5;
  localparam int unsigned FILTER_SIZE   = 3;
  localparam int unsigned STRIDE        = 1;
  localparam int unsigned OFMAP_SIZE    = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int unsigned RES_WIDTH     = 2 * IP_DATA_WIDTH;

  localparam int unsigned FLT_WORDS = FILTER_SIZE * FILTER_SIZE;
  localparam int unsigned IFM_WORDS = IFMAP_SIZE * IFMAP_SIZE;
  localparam int unsigned OFM_WORDS = OFMAP_SIZE * OFMAP_SIZE;

  // Counter and index widths; clamped to 1 so degenerate sizes still elaborate.
  localparam int unsigned LOAD_WORDS = (IFM_WORDS > FLT_WORDS) ? IFM_WORDS : FLT_WORDS;
  localparam int unsigned CNT_W      = (LOAD_WORDS > 1) ? $clog2(LOAD_WORDS) : 1;
  localparam int unsigned FLT_IDX_W  = (FLT_WORDS > 1) ? $clog2(FLT_WORDS) : 1;
  localparam int unsigned IFM_IDX_W  = (IFM_WORDS > 1) ? $clog2(IFM_WORDS) : 1;
  localparam int unsigned OFM_IDX_W  = (OFM_WORDS > 1) ? $clog2(OFM_WORDS) : 1;
  localparam int unsigned LAT_W      = 4;
  localparam int unsigned FS_W       = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int unsigned IS_W       = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
  localparam int unsigned OS_W       = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;

  // Matrix views, [row][col][bits]; row-major, so element [r][c] sits at word r*SIZE+c.
  typedef logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] flt_bank_t;
  typedef logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifm_bank_t;
  typedef logic [OFMAP_SIZE-1:0][OFMAP_SIZE-1:0][RES_WIDTH-1:0]       ofm_bank_t;

  // Flat word views of the same bits, indexed by raster position.
  typedef logic [FLT_WORDS-1:0][IP_DATA_WIDTH-1:0] flt_flat_t;
  typedef logic [IFM_WORDS-1:0][IP_DATA_WIDTH-1:0] ifm_flat_t;
  typedef logic [OFM_WORDS-1:0][RES_WIDTH-1:0]     ofm_flat_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoadFlt,
    StLoadIfm,
    StCompute,
    StDrain
  } conv_state_e;

endpackage

// File: rtl/conv_ctrl_if.sv
// Input word stream and output pixel stream of conv_ctrl.
// master = feeder/downstream side, slave = conv_ctrl.
interface conv_ctrl_if;
  import yolo_params_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [IP_DATA_WIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [RES_WIDTH-1:0]     out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/conv_out_drain.sv
// Ofmap drain: holds the captured result matrix and streams it out in raster order.
module conv_out_drain
  import yolo_params_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic                 active,
  input  ofm_bank_t            result_i,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [RES_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 drain_done
);

  localparam logic [OFM_IDX_W-1:0] OfmLast = OFM_IDX_W'(OFM_WORDS - 1);

  ofm_flat_t            res_q;
  logic [OFM_IDX_W-1:0] idx_q;
  logic                 fire;

  // Result register and pixel index; capture restarts the index at pixel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      idx_q <= '0;
    end else if (capture) begin
      res_q <= result_i;
      idx_q <= '0;
    end else if (fire) begin
      idx_q <= (idx_q == OfmLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Output view; data and last depend only on registered state, so they hold under stall.
  always_comb begin
    out_valid  = active;
    out_data   = res_q[idx_q];
    out_last   = active && (idx_q == OfmLast);
    fire       = active && out_ready;
    drain_done = fire && (idx_q == OfmLast);
  end

endmodule

// File: rtl/convolution.sv
// Combinational convolution datapath: result[r][c] = sum filter[i][j] * ifmap[r*S+i][c*S+j],
// truncated to RES_WIDTH bits.
module convolution
  import yolo_params_pkg::*;
(
  input  flt_bank_t filter,
  input  ifm_bank_t ifmap,
  output ofm_bank_t result_matrix
);

  // Multiply-accumulate over every output pixel.
  always_comb begin
    result_matrix = '0;
    for (int unsigned r = 0; r < OFMAP_SIZE; r++) begin
      for (int unsigned c = 0; c < OFMAP_SIZE; c++) begin
        for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
          for (int unsigned j = 0; j < FILTER_SIZE; j++) begin
            int unsigned y;
            int unsigned x;
            y = r * STRIDE + i;
            x = c * STRIDE + j;
            result_matrix[r[OS_W-1:0]][c[OS_W-1:0]] =
                result_matrix[r[OS_W-1:0]][c[OS_W-1:0]] +
                RES_WIDTH'(filter[i[FS_W-1:0]][j[FS_W-1:0]]) *
                RES_WIDTH'(ifmap[y[IS_W-1:0]][x[IS_W-1:0]]);
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_ctrl.sv
// Sequencer for the convolution datapath: loads filter then ifmap banks from one word
// stream, waits COMPUTE_LAT cycles, captures the result and drains it pixel by pixel.
// Optional build macro CONV_CTRL_FILTER_KEEP_EN adds keep_filter, letting a job skip the
// filter load and reuse the previous filter bank.
module conv_ctrl
  import yolo_params_pkg::*;
#(
  parameter int unsigned COMPUTE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef CONV_CTRL_FILTER_KEEP_EN
  input  logic       keep_filter,
`endif
  output logic       busy,
  output logic       done,
  conv_ctrl_if.slave bus,
  output flt_bank_t  filter_o,
  output ifm_bank_t  ifmap_o,
  input  ofm_bank_t  result_i
);

  localparam logic [CNT_W-1:0] FltLast = CNT_W'(FLT_WORDS - 1);
  localparam logic [CNT_W-1:0] IfmLast = CNT_W'(IFM_WORDS - 1);
  localparam logic [LAT_W-1:0] LatInit = LAT_W'(COMPUTE_LAT - 1);

  conv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [LAT_W-1:0] lat_q;
  flt_flat_t        flt_q;
  ifm_flat_t        ifm_q;
  logic             done_q;
  logic             skip_flt;
  logic             in_fire;
  logic             last_beat;
  logic             capture;
  logic             drain_active;
  logic             drain_done;

`ifdef CONV_CTRL_FILTER_KEEP_EN
  assign skip_flt = keep_filter;
`else
  assign skip_flt = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = skip_flt ? StLoadIfm : StLoadFlt;
      StLoadFlt: if (in_fire && cnt_q == FltLast) state_d = StLoadIfm;
      StLoadIfm: if (in_fire && cnt_q == IfmLast) state_d = StCompute;
      StCompute: if (lat_q == '0) state_d = StDrain;
      StDrain:   if (drain_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State-decoded outputs and strobes.
  always_comb begin
    busy         = (state_q != StIdle);
    bus.in_ready = (state_q == StLoadFlt) || (state_q == StLoadIfm);
    in_fire      = bus.in_valid && bus.in_ready;
    last_beat    = ((state_q == StLoadFlt) && (cnt_q == FltLast)) ||
                   ((state_q == StLoadIfm) && (cnt_q == IfmLast));
    capture      = (state_q == StCompute) && (lat_q == '0);
    drain_active = (state_q == StDrain);
    done         = done_q;
  end

  // Word counter, latency counter, load banks and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lat_q  <= '0;
      flt_q  <= '0;
      ifm_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= drain_done;
      if (state_q == StIdle) begin
        cnt_q <= '0;
      end else if (in_fire) begin
        if (state_q == StLoadFlt) flt_q[cnt_q[FLT_IDX_W-1:0]] <= bus.in_data;
        else                      ifm_q[cnt_q[IFM_IDX_W-1:0]] <= bus.in_data;
        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      end
      if ((state_q == StLoadIfm) && in_fire && last_beat) begin
        lat_q <= LatInit;
      end else if ((state_q == StCompute) && (lat_q != '0)) begin
        lat_q <= lat_q - 1'b1;
      end
    end
  end

  assign filter_o = flt_q;
  assign ifmap_o  = ifm_q;

  conv_out_drain u_drain (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (capture),
    .active     (drain_active),
    .result_i   (result_i),
    .out_ready  (bus.out_ready),
    .out_valid  (bus.out_valid),
    .out_data   (bus.out_data),
    .out_last   (bus.out_last),
    .drain_done (drain_done)
  );

endmodule

// File: doc/conv_ctrl.md
Name: conv_ctrl

Overview:
- Sequencer for the `convolution` datapath.
- Takes one word stream on a valid/ready handshake and loads it into the filter register bank, then into the ifmap register bank. These banks drive the combinational `convolution` instance.
- After a fixed settle time it registers `result_matrix` and streams the ofmap out in raster order on a second valid/ready handshake.
- Sits between the layer DMA/line feeder and the downstream pooling/activation stage.

Parameters:
- COMPUTE_LAT, 2, cycles between the last ifmap beat and the result capture (range 1..15). Covers the datapath settle time and any retiming.
- Sizes (IP_DATA_WIDTH, IFMAP_SIZE, FILTER_SIZE, OFMAP_SIZE, STRIDE) come from `yolo_params_pkg`. They are not parameters of this block.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one convolution job; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final output beat
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts an input word
- in_data  in  IP_DATA_WIDTH  filter words, then ifmap words, raster (row-major) order
- filter_o  out  IP_DATA_WIDTH x FILTER_SIZE x FILTER_SIZE  to convolution filter
- ifmap_o  out  IP_DATA_WIDTH x IFMAP_SIZE x IFMAP_SIZE  to convolution ifmap
- result_i  in  2*IP_DATA_WIDTH x OFMAP_SIZE x OFMAP_SIZE  from convolution result_matrix
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts a pixel
- out_data  out  2*IP_DATA_WIDTH  ofmap pixel
- out_last  out  1  high with the final pixel (index OFMAP_SIZE*OFMAP_SIZE-1)

Behaviour:
- Reset (async assert, sync release) clears all outputs, banks, counters and the result register to 0; state goes to IDLE.
- **FSM states: IDLE, LOAD_FLT, LOAD_IFM, COMPUTE, DRAIN.**
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> LOAD_FLT; word counter cleared.
- LOAD_FLT:
  - in_ready=1. Each in_valid&&in_ready writes filter[cnt/FILTER_SIZE][cnt%FILTER_SIZE] and increments cnt.
  - On beat FILTER_SIZE^2-1 -> LOAD_IFM with cnt=0.
- LOAD_IFM:
  - Same rule for ifmap, using IFMAP_SIZE.
  - On beat IFMAP_SIZE^2-1 -> COMPUTE with the latency counter loaded to COMPUTE_LAT-1.
- COMPUTE:
  - in_ready=0. The counter decrements each cycle.
  - At 0, result_i is captured into an internal result register and the state goes to DRAIN with pixel index 0.
  - Total: the capture occurs COMPUTE_LAT cycles after the last ifmap handshake.
- DRAIN:
  - out_valid=1; out_data = result[idx/OFMAP_SIZE][idx%OFMAP_SIZE].
  - idx increments on out_valid&&out_ready. out_data and out_last stay stable while out_ready=0.
  - The final transfer -> IDLE, with done=1 for exactly that next cycle.
- start while busy is ignored; no queueing.
- in_valid in IDLE/COMPUTE/DRAIN is not consumed (in_ready=0).
- Bubbles (in_valid=0) stall the counter with no effect. Arbitrary out_ready backpressure is legal.
- filter_o/ifmap_o hold their values after the job until overwritten by the next load. The result register is independent of the banks.
- Counters are sized with $clog2 of their maximum count; no wrap beyond the terminal count.
- Reset mid-job aborts immediately: all state cleared, no done pulse.

Optional Feature:
- Macro: CONV_CTRL_FILTER_KEEP_EN.
- When defined:
  - Adds input port keep_filter (1 bit), sampled together with start.
  - start&&keep_filter goes IDLE -> LOAD_IFM directly, reusing the filter bank from the previous job (all zeros if none since reset).
- When undefined: no such port; every job loads the filter.

Decomposition:
- `yolo_params_pkg` gains:
  - `conv_state_e` enum (IDLE..DRAIN);
  - localparams FLT_WORDS=FILTER_SIZE*FILTER_SIZE, IFM_WORDS=IFMAP_SIZE*IFMAP_SIZE, OFM_WORDS=OFMAP_SIZE*OFMAP_SIZE;
  - counter width localparams.
- One natural sub-module: `conv_out_drain`. It holds the result register, pixel index, out_valid/out_last/out_data, and returns a drain_done strobe.
- The FSM and load banks stay in `conv_ctrl`.

Test Plan (package set to IFMAP_SIZE=5, FILTER_SIZE=3, STRIDE=1, OFMAP_SIZE=3, IP_DATA_WIDTH=8; COMPUTE_LAT=2; `convolution` instantiated in the bench):
- Basic job: start, 9 filter words of 1, then 25 ifmap words of 2, out_ready=1 -> 9 pixels of 18; out_last on the 9th; done pulses one cycle later; busy low afterwards.
- Raster order: filter is 1 at [0][0] and 0 elsewhere; ifmap word n = n (0..24) -> outputs 0,1,2,5,6,7,10,11,12.
- Input bubbles plus output backpressure: in_valid toggles at 50% and out_ready is held low 3 cycles per pixel -> same values as the basic job; out_data stays stable while stalled; no lost or duplicated beat.
- start pulsed during LOAD_IFM and DRAIN -> ignored; exactly one done per accepted start.
- rst_n asserted in the middle of LOAD_IFM -> all outputs 0 asynchronously; a following clean job produces correct results.
- With CONV_CTRL_FILTER_KEEP_EN: job 1 uses filter of all 1s; job 2 has keep_filter=1 and 25 words of 3 -> 9 pixels of 27; in_ready never accepts filter words in job 2.
